// File: rtl/lcplc_pkg.sv
// Shared LCPLC definitions: default widths, the kj output FSM encoding,
// and a small elaboration-time helper.
package lcplc_pkg;

  localparam int MAPPED_ERROR_WIDTH_DEFAULT = 19;
  localparam int KJ_WIDTH_DEFAULT           = 5;
  localparam int ACCUMULATOR_WINDOW_DEFAULT = 32;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } kj_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kj_search.sv
// Combinational Golomb parameter search: smallest k with (cnt << k) >= acc,
// saturating at 2^KJ_WIDTH-1. Shared between the encoder and the decoder.
module kj_search
  import lcplc_pkg::*;
#(
  parameter int ACC_W    = 25,
  parameter int CNT_W    = 6,
  parameter int KJ_WIDTH = KJ_WIDTH_DEFAULT
) (
  input  logic [ACC_W-1:0]    acc,
  input  logic [CNT_W-1:0]    cnt,
  output logic [KJ_WIDTH-1:0] kj
);

  localparam int KJ_MAX = (1 << KJ_WIDTH) - 1;
  // Wide enough that no shift of cnt can overflow and acc always fits.
  localparam int EXT_W  = max_int(CNT_W + KJ_MAX, ACC_W) + 1;

  always_comb begin
    kj = KJ_WIDTH'(KJ_MAX);
    for (int k = KJ_MAX - 1; k >= 0; k--) begin
      if ((EXT_W'(cnt) << k) >= EXT_W'(acc)) begin
        kj = KJ_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/kj_calculator.sv
// Adaptive Golomb parameter calculator with a one-deep registered output stage.
// Optional macro KJ_CALCULATOR_BLOCK_RESET_EN restarts statistics at each block end.
module kj_calculator
  import lcplc_pkg::*;
#(
  parameter int MAPPED_ERROR_WIDTH = MAPPED_ERROR_WIDTH_DEFAULT,
  parameter int ACCUMULATOR_WINDOW = ACCUMULATOR_WINDOW_DEFAULT,
  parameter int KJ_WIDTH           = KJ_WIDTH_DEFAULT,
  parameter int ACC_INIT           = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MAPPED_ERROR_WIDTH-1:0] ehat_data,
  input  logic                          ehat_valid,
  output logic                          ehat_ready,
  input  logic                          ehat_last_b,
  output logic [KJ_WIDTH-1:0]           kj_data,
  output logic                          kj_valid,
  input  logic                          kj_ready
);

  localparam int WIN_LOG2 = $clog2(ACCUMULATOR_WINDOW);
  localparam int ACC_W    = MAPPED_ERROR_WIDTH + WIN_LOG2 + 1;
  localparam int CNT_W    = WIN_LOG2 + 1;

  kj_state_t           state;
  logic [ACC_W-1:0]    acc, acc_sum, acc_nxt;
  logic [CNT_W-1:0]    cnt, cnt_inc, cnt_nxt;
  logic [KJ_WIDTH-1:0] kj_now;
  logic                accept;

  assign ehat_ready = (state == IDLE) || kj_ready;
  assign kj_valid   = (state == FULL);
  assign accept     = ehat_valid && ehat_ready;

  kj_search #(
    .ACC_W   (ACC_W),
    .CNT_W   (CNT_W),
    .KJ_WIDTH(KJ_WIDTH)
  ) u_kj_search (
    .acc(acc),
    .cnt(cnt),
    .kj (kj_now)
  );

  // Statistics after adding the current sample, halved when the window fills.
  always_comb begin
    cnt_inc = cnt + CNT_W'(1);
    acc_sum = acc + ACC_W'(ehat_data);
    if (cnt_inc == CNT_W'(ACCUMULATOR_WINDOW)) begin
      acc_nxt = acc_sum >> 1;
      cnt_nxt = cnt_inc >> 1;
    end else begin
      acc_nxt = acc_sum;
      cnt_nxt = cnt_inc;
    end
`ifdef KJ_CALCULATOR_BLOCK_RESET_EN
    if (ehat_last_b) begin
      acc_nxt = ACC_W'(ACC_INIT);
      cnt_nxt = CNT_W'(1);
    end
`endif
  end

`ifndef KJ_CALCULATOR_BLOCK_RESET_EN
  logic unused_last_b;
  assign unused_last_b = ehat_last_b;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      kj_data <= '0;
      acc     <= ACC_W'(ACC_INIT);
      cnt     <= CNT_W'(1);
    end else begin
      if (accept) begin
        state   <= FULL;
        kj_data <= kj_now;
        acc     <= acc_nxt;
        cnt     <= cnt_nxt;
      end else if (kj_valid && kj_ready) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_kj_calculator.sv
// Self-checking bench for kj_calculator: behavioural statistics model,
// per-cycle compare process, directed literal cases and random throttling.
module tb_kj_calculator;

  localparam int MEW     = 19;
  localparam int WIN     = 32;
  localparam int KJW     = 5;
  localparam int ACCI    = 1;
  localparam int KJ_MAX  = (1 << KJW) - 1;

  logic           clk;
  logic           rst;
  logic [MEW-1:0] ehat_data;
  logic           ehat_valid;
  logic           ehat_ready;
  logic           ehat_last_b;
  logic [KJW-1:0] kj_data;
  logic           kj_valid;
  logic           kj_ready;

  int compared   = 0;
  int mismatched = 0;
  int ready_mode = 0;

  longint m_acc;
  longint m_cnt;
  int     exp_q[$];
  int     got_q[$];
  bit     held;
  int     held_data;

  kj_calculator #(
    .MAPPED_ERROR_WIDTH(MEW),
    .ACCUMULATOR_WINDOW(WIN),
    .KJ_WIDTH          (KJW),
    .ACC_INIT          (ACCI)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ehat_data  (ehat_data),
    .ehat_valid (ehat_valid),
    .ehat_ready (ehat_ready),
    .ehat_last_b(ehat_last_b),
    .kj_data    (kj_data),
    .kj_valid   (kj_valid),
    .kj_ready   (kj_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint got, input longint exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Golomb parameter from first principles: smallest k with cnt*2^k >= acc.
  function automatic int model_kj(input longint acc, input longint cnt);
    for (int k = 0; k <= KJ_MAX; k++) begin
      if ((cnt * (64'd1 << k)) >= acc) return k;
    end
    return KJ_MAX;
  endfunction

  task automatic model_add(input longint d, input bit last);
`ifdef KJ_CALCULATOR_BLOCK_RESET_EN
    if (last) begin
      m_acc = ACCI;
      m_cnt = 1;
      return;
    end
`endif
    m_acc += d;
    m_cnt += 1;
    if (m_cnt == WIN) begin
      m_acc = m_acc / 2;
      m_cnt = m_cnt / 2;
    end
  endtask

  // Compare process: one look per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_acc = ACCI;
      m_cnt = 1;
      held  = 1'b0;
    end else begin
      if (held) begin
        checkOutput("hold_valid", kj_valid, 1);
        checkOutput("hold_data", kj_data, held_data);
      end
      checkOutput("ehat_ready", ehat_ready, (!kj_valid || kj_ready) ? 1 : 0);
      if (kj_valid && kj_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_kj_count", 1, 0);
        end else begin
          checkOutput("kj_data", kj_data, exp_q.pop_front());
        end
        got_q.push_back(int'(kj_data));
      end
      held      = kj_valid && !kj_ready;
      held_data = int'(kj_data);
      if (ehat_valid && ehat_ready) begin
        exp_q.push_back(model_kj(m_acc, m_cnt));
        model_add(longint'(ehat_data), ehat_last_b);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       kj_ready = 1'b1;
      1:       kj_ready = ($urandom_range(0, 2) != 0);
      default: kj_ready = 1'b0;
    endcase
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_kj_valid", kj_valid, 0);
    checkOutput("reset_kj_data", kj_data, 0);
    checkOutput("reset_ehat_ready", ehat_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic applyStimulus(input int d, input bit last);
    bit done = 1'b0;
    ehat_valid  = 1'b1;
    ehat_data   = MEW'(d);
    ehat_last_b = last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (ehat_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    ehat_valid  = 1'b0;
    ehat_last_b = 1'b0;
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    ready_mode = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !kj_valid) done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", 0, 1);
  endtask

  task automatic check_got(input string name, input int idx, input int exp);
    if (got_q.size() <= idx) checkOutput({name, "_missing"}, got_q.size(), idx + 1);
    else checkOutput(name, got_q[idx], exp);
  endtask

  initial begin
    rst         = 1'b1;
    ehat_valid  = 1'b0;
    ehat_data   = '0;
    ehat_last_b = 1'b0;
    kj_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ehat=10 then 0: acc 11, cnt 2 -> kj 3
    do_reset();
    applyStimulus(10, 0);
    applyStimulus(0, 0);
    drain();
    check_got("lit_first_kj", 0, 0);
    check_got("lit_second_kj", 1, 3);

    // 31 zeros then one more: window halving leaves acc 0, cnt 16
    do_reset();
    for (int i = 0; i < 32; i++) applyStimulus(0, 0);
    drain();
    checkOutput("lit_zero_run_count", got_q.size(), 32);
    for (int i = 0; i < 32; i++) check_got("lit_zero_run_kj", i, 0);
    checkOutput("model_after_halve_cnt", m_cnt, 17);
    checkOutput("model_after_halve_acc", m_acc, 0);

    // Largest mapped error
    do_reset();
    applyStimulus((1 << MEW) - 1, 0);
    applyStimulus(0, 0);
    drain();
    check_got("lit_max_first", 0, 0);
    check_got("lit_max_second", 1, 18);

    // Backpressure: hold kj_ready low for five cycles
    do_reset();
    ready_mode = 2;
    @(posedge clk);
    #1;
    applyStimulus(7, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_kj_valid", kj_valid, 1);
      checkOutput("stall_ehat_ready", ehat_ready, 0);
      checkOutput("stall_kj_data", kj_data, 0);
    end
    @(posedge clk);
    #1;
    drain();
    checkOutput("stall_pop_count", got_q.size(), 1);

    // Block end marker
    do_reset();
    applyStimulus(100, 1);
    applyStimulus(0, 0);
    drain();
    check_got("lit_block_first", 0, 0);
`ifdef KJ_CALCULATOR_BLOCK_RESET_EN
    check_got("lit_block_second", 1, 0);
`else
    check_got("lit_block_second", 1, 6);
`endif

    // Reset while a kj is held discards it
    ready_mode = 2;
    @(posedge clk);
    #1;
    applyStimulus(3, 0);
    @(negedge clk);
    checkOutput("pre_reset_kj_valid", kj_valid, 1);
    @(posedge clk);
    #1;
    do_reset();
    ready_mode = 0;
    @(negedge clk);
    checkOutput("post_reset_kj_valid", kj_valid, 0);
    @(posedge clk);
    #1;

    // Random throttling on both sides
    ready_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      int d;
      case ($urandom_range(0, 3))
        0:       d = int'($urandom & 32'hF);
        1:       d = int'($urandom & 32'hFF);
        2:       d = int'($urandom & ((32'd1 << MEW) - 1));
        default: d = 0;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      applyStimulus(d, ($urandom_range(0, 19) == 0));
    end
    drain();
    checkOutput("random_exp_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
